// File: rtl/regfile32_flat.sv
// 32 x WIDTH register file: one write port, two mux32to1by32 read ports, and a
// one-register-per-cycle clear sweep. Define WRITE_BYPASS_EN for write-through read forwarding.

module mux32to1by32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [32*WIDTH-1:0] bus_i,
  input  logic [4:0]          sel_i,
  output logic [WIDTH-1:0]    data_o
);

  logic [31:0][WIDTH-1:0] words;

  assign words  = bus_i;
  assign data_o = words[sel_i];

endmodule

module regfile32_flat #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CLEAR_START = 1
) (
  input  logic                Clk,
  input  logic                ResetN,
  input  logic                RegWrite,
  input  logic [4:0]          WriteRegister,
  input  logic [WIDTH-1:0]    WriteData,
  input  logic [4:0]          ReadRegister1,
  input  logic [4:0]          ReadRegister2,
  input  logic                ClearReq,
  output logic [WIDTH-1:0]    ReadData1,
  output logic [WIDTH-1:0]    ReadData2,
  output logic [32*WIDTH-1:0] RegBus,
  output logic                Busy
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e                 state_q;
  logic [4:0]             cnt_q;
  logic                   busy_q;
  logic [31:0][WIDTH-1:0] regs_q;
  logic                   wr_en;
  logic [WIDTH-1:0]       mux1_data;
  logic [WIDTH-1:0]       mux2_data;

  // Writes only land in IDLE; entry 0 is never written so it stays zero after reset.
  assign wr_en = (state_q == StIdle) && RegWrite && (WriteRegister != 5'd0);

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      regs_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (wr_en) begin
            regs_q[WriteRegister] <= WriteData;
          end
          if (ClearReq) begin
            state_q <= StClear;
            cnt_q   <= 5'(CLEAR_START);
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          regs_q[cnt_q] <= '0;
          if (cnt_q == 5'd31) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign RegBus = regs_q;
  assign Busy   = busy_q;

  mux32to1by32 #(
    .WIDTH (WIDTH)
  ) u_mux_rd1 (
    .bus_i  (RegBus),
    .sel_i  (ReadRegister1),
    .data_o (mux1_data)
  );

  mux32to1by32 #(
    .WIDTH (WIDTH)
  ) u_mux_rd2 (
    .bus_i  (RegBus),
    .sel_i  (ReadRegister2),
    .data_o (mux2_data)
  );

`ifdef WRITE_BYPASS_EN
  // wr_en already excludes address 0 and the sweep, so forwarding inherits both rules.
  always_comb begin
    ReadData1 = mux1_data;
    ReadData2 = mux2_data;
    if (wr_en && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = WriteData;
    end
    if (wr_en && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = WriteData;
    end
  end
`else
  assign ReadData1 = mux1_data;
  assign ReadData2 = mux2_data;
`endif

endmodule

// File: doc/regfile32_flat.md
Name: regfile32_flat

Overview:
- 32-entry x 32-bit register file with one write port and two read ports.
- Sits directly upstream of the 32:1 word muxes. It drives the packed 1024-bit register bus that each read-port mux consumes, and instantiates mux32to1by32 twice for the read ports.
- Register 0 reads as zero at all times.
- Includes a sequential clear engine that zeroes registers 1..31 one per cycle on command.

Parameters:
- WIDTH, 32, data width of each register; the flat bus is 32*WIDTH bits.
- CLEAR_START, 1, first register index touched by the clear sweep; must be 1.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- ResetN  input  1  synchronous active-low reset, sampled on rising edge of Clk.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  write address.
- WriteData  input  32  write data.
- ReadRegister1  input  5  read port 1 address.
- ReadRegister2  input  5  read port 2 address.
- ClearReq  input  1  one-cycle pulse that starts a clear sweep.
- ReadData1  output  32  read port 1 data.
- ReadData2  output  32  read port 2 data.
- RegBus  output  1024  packed registers; register i occupies bits [32*i+31:32*i].
- Busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset: when ResetN=0 at a rising edge:
  - all 32 registers go to 0 and FSM goes to IDLE.
  - Busy=0, RegBus=0.
  - ReadData1 and ReadData2 read 0 (combinational from cleared state).
- Reset takes priority over every other input, including mid-sweep; the sweep counter is discarded.
- Write: in IDLE, with RegWrite=1 and WriteRegister!=0, reg[WriteRegister] <= WriteData at the rising edge. Visible on RegBus and the read ports from the next cycle.
- Writes to address 0 are ignored; reg[0] stays 0 always, including its RegBus slice.
- Read: ReadDataN = reg[ReadRegisterN], combinational through mux32to1by32 fed by RegBus. Latency is 0 cycles from address change.
- Read-during-write to the same address returns the old value unless WRITE_BYPASS_EN is defined.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when ClearReq=1. Counter loads CLEAR_START. Busy rises the following cycle.
  - CLEAR: each cycle reg[counter] <= 0 and counter increments.
  - After clearing reg[31], return to IDLE; Busy falls the cycle after reg[31] is cleared.
  - A sweep therefore holds Busy high for exactly 31 cycles.
- During CLEAR:
  - RegWrite is ignored (dropped, not queued).
  - ClearReq is ignored; the sweep does not restart.
- Simultaneous ClearReq and RegWrite in IDLE: the write is performed that edge, and the clear then erases it during the sweep.
- Counter is 5 bits; the terminal check is on value 31, so it never wraps to 0.

Optional Feature:
- Macro: WRITE_BYPASS_EN.
- Defined: if RegWrite=1, FSM is in IDLE, WriteRegister!=0, and ReadRegisterN==WriteRegister, then ReadDataN = WriteData in the same cycle (write-through forwarding).
  - Bypass never applies to address 0.
  - Bypass never applies while Busy=1.
- Not defined: read ports always return stored register contents; no forwarding logic is generated.

Test Plan:
- Reset: hold ResetN=0 for 2 cycles after random writes -> RegBus=0, Busy=0, ReadData1=ReadData2=0.
- Write/read: write 0xDEADBEEF to r5, 0x12345678 to r31 -> next cycle ReadRegister1=5 gives 0xDEADBEEF, ReadRegister2=31 gives 0x12345678, RegBus[1023:992]=0x12345678.
- Zero register: write 0xFFFFFFFF to r0 -> ReadData1 at address 0 is 0, RegBus[31:0]=0.
- Same-address read-during-write: r7=0xA, then write 0xB to r7 while reading r7 -> 0xA without the macro, 0xB with WRITE_BYPASS_EN. Next cycle reads 0xB in both builds.
- Clear sweep: fill r1..r31 with index values and pulse ClearReq:
  - Busy high for exactly 31 cycles.
  - RegWrite to r3 mid-sweep is dropped.
  - Final state: all registers 0.
- Reset mid-sweep: ResetN=0 at sweep cycle 10 -> next cycle Busy=0, all registers 0, FSM in IDLE. A write to r2 on the following cycle succeeds.
